shift_arb: RTL and testbench

- Shares one `shift16` datapath (16-bit; ops ROL/SLL/ROR/ASR; 4-bit count) between two requesters, e.g. the ALU and the address/immediate unit.
- Arbitrates round-robin and latches the winner's operands.
- Drives the shifter for one cycle, registers the result and returns it with a valid/ack handshake to the granted port.
- Sits beside the ALU in the execute stage as the only owner of the shifter instance.

---
 rtl/shift_pkg.sv | 17 +
 rtl/rr_arb2.sv | 17 +
 rtl/shift16.sv | 28 ++
 rtl/shift_arb.sv | 138 +++++++++++++
 tb/tb_shift_arb.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op codes, FSM states and datapath width.
package shift_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_ROL = 2'd0;
  localparam logic [1:0] OP_SLL = 2'd1;
  localparam logic [1:0] OP_ROR = 2'd2;
  localparam logic [1:0] OP_ASR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-grant state lives in the parent.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
      else                gnt_o = req_i;
    end
  end

endmodule

// File: rtl/shift16.sv
// 16-bit combinational shifter: rotate left/right, logical left, arithmetic right.
module shift16
  import shift_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [3:0]  cnt_i,
  input  logic [15:0] din_i,
  output logic [15:0] dout_o
);

  logic [31:0] dbl_l;
  logic [31:0] dbl_r;

  // Rotates come from shifting a doubled copy of the operand.
  always_comb begin
    dbl_l  = {din_i, din_i} << cnt_i;
    dbl_r  = {din_i, din_i} >> cnt_i;
    dout_o = din_i;
    case (op_i)
      OP_ROL:  dout_o = dbl_l[31:16];
      OP_SLL:  dout_o = din_i << cnt_i;
      OP_ROR:  dout_o = dbl_r[15:0];
      OP_ASR:  dout_o = $signed(din_i) >>> cnt_i;
      default: dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// Round-robin sharing of one shift16 between two requesters with valid/ack return.
// Optional grant counters gcnt0/gcnt1 are built when SHIFT_ARB_STAT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; grant decoded combinationally
// EXEC  | latched operands drive the shifter
// RESP  | result held with vld to the selected port until its ack
module shift_arb #(
  parameter int DATA_W = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [1:0]        op0,
  input  logic [3:0]        cnt0,
  input  logic [DATA_W-1:0] in0,
  output logic              gnt0,
  output logic              vld0,
  input  logic              ack0,
  input  logic              req1,
  input  logic [1:0]        op1,
  input  logic [3:0]        cnt1,
  input  logic [DATA_W-1:0] in1,
  output logic              gnt1,
  output logic              vld1,
  input  logic              ack1,
  output logic [DATA_W-1:0] res,
  output logic              busy
`ifdef SHIFT_ARB_STAT_EN
  ,
  output logic [STAT_W-1:0] gcnt0,
  output logic [STAT_W-1:0] gcnt1
`endif
);

  import shift_pkg::*;

  if (DATA_W != shift_pkg::DATA_W) begin : g_bad_width
    $error("shift_arb: DATA_W must be 16 to match shift16");
  end

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] in_q, in_d;
  logic [15:0] res_q, res_d;
  logic [1:0]  gnt;
  logic [15:0] sh_out;

  // Reset gates the grant so nothing is offered while rst is held.
  rr_arb2 u_arb (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .en_i   ((state_q == IDLE) && !rst),
    .gnt_o  (gnt)
  );

  shift16 u_shift (
    .op_i   (op_q),
    .cnt_i  (cnt_q),
    .din_i  (in_q),
    .dout_o (sh_out)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (|gnt) begin
        sel_d   = gnt[1];
        last_d  = gnt[1];
        op_d    = gnt[1] ? op1  : op0;
        cnt_d   = gnt[1] ? cnt1 : cnt0;
        in_d    = gnt[1] ? in1  : in0;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = sh_out;
        state_d = RESP;
      end
      RESP: if (sel_q ? ack1 : ack0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign vld0 = (state_q == RESP) && !sel_q;
  assign vld1 = (state_q == RESP) && sel_q;
  assign res  = res_q;
  assign busy = (state_q != IDLE);

`ifdef SHIFT_ARB_STAT_EN
  logic [STAT_W-1:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (gnt[0] && (gcnt0_q != '1)) gcnt0_q <= gcnt0_q + STAT_W'(1);
      if (gnt[1] && (gcnt1_q != '1)) gcnt1_q <= gcnt1_q + STAT_W'(1);
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb: directed scenarios plus randomized traffic against a bit-level model.
module tb_shift_arb;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, ack0, ack1;
  logic [1:0]  op0, op1;
  logic [3:0]  cnt0, cnt1;
  logic [15:0] in0, in1;
  logic        gnt0, gnt1, vld0, vld1, busy;
  logic [15:0] res;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  shift_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .cnt0(cnt0), .in0(in0), .gnt0(gnt0), .vld0(vld0), .ack0(ack0),
    .req1(req1), .op1(op1), .cnt1(cnt1), .in1(in1), .gnt1(gnt1), .vld1(vld1), .ack1(ack1),
    .res(res), .busy(busy)
`ifdef SHIFT_ARB_STAT_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
  );

`ifdef SHIFT_ARB_STAT_EN
  logic [15:0] gcnt0, gcnt1;
  logic        s_gnt0, s_gnt1, s_vld0, s_vld1, s_busy;
  logic [15:0] s_res;
  logic [1:0]  s_gcnt0, s_gcnt1;

  shift_arb #(.STAT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .cnt0(cnt0), .in0(in0), .gnt0(s_gnt0), .vld0(s_vld0), .ack0(ack0),
    .req1(req1), .op1(op1), .cnt1(cnt1), .in1(in1), .gnt1(s_gnt1), .vld1(s_vld1), .ack1(ack1),
    .res(s_res), .busy(s_busy), .gcnt0(s_gcnt0), .gcnt1(s_gcnt1)
  );
`endif

  // Reference shifter expressed bit by bit from the op definitions.
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input int c, input logic [15:0] d);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      case (op)
        OP_ROL:  r[(i + c) % 16] = d[i];
        OP_SLL:  r[i] = (i >= c) ? d[i - c] : 1'b0;
        OP_ROR:  r[i] = d[(i + c) % 16];
        default: r[i] = (i + c < 16) ? d[i + c] : d[15];
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if ((gnt0 & gnt1) !== 1'b0) begin
        n_err++;
        $display("FAIL gnt_exclusive t=%0t got gnt0=%b gnt1=%b want not both", $time, gnt0, gnt1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
    op0 = 0; op1 = 0; cnt0 = 0; cnt1 = 0; in0 = 0; in1 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req1 = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, vld0, vld1, busy, res} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %b/%b/%b/%b/%b/%h want all 0", gnt0, gnt1, vld0, vld1, busy, res);
    end
    req1 = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle got gnt=%b%b busy=%b want 000", gnt0, gnt1, busy);
    end
  endtask

  task automatic test_port0_rol();
    step();
    req0 = 1; op0 = OP_ROL; cnt0 = 4'd4; in0 = 16'h00EA;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, busy} !== 3'b100) begin
      n_err++; $display("FAIL p0_gnt_c0 got gnt=%b%b busy=%b want 100", gnt0, gnt1, busy);
    end
    step();
    req0 = 0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, vld0, busy} !== 3'b001) begin
      n_err++; $display("FAIL p0_exec_c1 got gnt0=%b vld0=%b busy=%b want 001", gnt0, vld0, busy);
    end
    step();
    @(negedge clk);
    n_vec++;
    if ({vld0, vld1, res} !== {2'b10, 16'h0EA0}) begin
      n_err++; $display("FAIL p0_rol_res got vld=%b%b res=%h want 10 0ea0", vld0, vld1, res);
    end
    ack0 = 1;
    step();
    ack0 = 0;
    @(negedge clk);
    n_vec++;
    if ({vld0, busy} !== 2'b00) begin
      n_err++; $display("FAIL p0_done_c3 got vld0=%b busy=%b want 00", vld0, busy);
    end
  endtask

  task automatic test_port1_ops();
    logic [1:0]  t_op[3]  = '{OP_ASR, OP_SLL, OP_ROR};
    logic [3:0]  t_cnt[3] = '{4'd4, 4'd12, 4'd8};
    logic [15:0] t_in[3]  = '{16'hFA7B, 16'h0018, 16'h3E15};
    logic [15:0] t_exp[3] = '{16'hFFA7, 16'h8000, 16'h153E};
    for (int k = 0; k < 3; k++) begin
      step();
      req1 = 1; op1 = t_op[k]; cnt1 = t_cnt[k]; in1 = t_in[k];
      @(negedge clk);
      n_vec++;
      if ({gnt0, gnt1} !== 2'b01) begin
        n_err++; $display("FAIL p1_gnt[%0d] got gnt=%b%b want 01", k, gnt0, gnt1);
      end
      step();
      req1 = 0; in1 = 16'hDEAD;
      step();
      @(negedge clk);
      n_vec++;
      if ({vld0, vld1, res} !== {2'b01, t_exp[k]}) begin
        n_err++; $display("FAIL p1_res[%0d] got vld=%b%b res=%h want 01 %h", k, vld0, vld1, res, t_exp[k]);
      end
      ack1 = 1;
      step();
      ack1 = 0;
    end
  endtask

  task automatic test_both_alternate();
    do_reset();
    req0 = 1; op0 = OP_ROL; cnt0 = 4'd0;  in0 = 16'h3E15;
    req1 = 1; op1 = OP_ROR; cnt1 = 4'd4;  in1 = 16'h00F0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL both_first got gnt=%b%b want 10", gnt0, gnt1);
    end
    step();
    req0 = 0;
    @(negedge clk);
    n_vec++;
    if (gnt1 !== 1'b0) begin
      n_err++; $display("FAIL both_wait_exec got gnt1=%b want 0", gnt1);
    end
    step();
    @(negedge clk);
    n_vec++;
    if ({vld0, res} !== {1'b1, 16'h3E15}) begin
      n_err++; $display("FAIL both_p0_res got vld0=%b res=%h want 1 3e15", vld0, res);
    end
    ack0 = 1;
    step();
    ack0 = 0;
    req0 = 1; op0 = OP_SLL; cnt0 = 4'd15; in0 = 16'h0001;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_err++; $display("FAIL both_second got gnt=%b%b want 01", gnt0, gnt1);
    end
    step();
    req1 = 0;
    step();
    @(negedge clk);
    n_vec++;
    if ({vld1, res} !== {1'b1, 16'h000F}) begin
      n_err++; $display("FAIL both_p1_res got vld1=%b res=%h want 1 000f", vld1, res);
    end
    ack1 = 1;
    step();
    ack1 = 0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL both_third got gnt=%b%b want 10", gnt0, gnt1);
    end
    step();
    req0 = 0;
    step();
    @(negedge clk);
    n_vec++;
    if ({vld0, res} !== {1'b1, 16'h8000}) begin
      n_err++; $display("FAIL both_p0_sll got vld0=%b res=%h want 1 8000", vld0, res);
    end
    ack0 = 1;
    step();
    ack0 = 0;
  endtask

  task automatic test_ack_hold();
    step();
    req0 = 1; op0 = OP_ASR; cnt0 = 4'd15; in0 = 16'h8000;
    step();
    req0 = 0;
    step();
    req1 = 1; op1 = OP_SLL; cnt1 = 4'd4; in1 = 16'h1234;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      n_vec++;
      if ({vld0, vld1, gnt1, res} !== {3'b100, 16'hFFFF}) begin
        n_err++; $display("FAIL hold[%0d] got vld=%b%b gnt1=%b res=%h want 100 ffff", h, vld0, vld1, gnt1, res);
      end
      step();
    end
    ack0 = 1;
    @(negedge clk);
    n_vec++;
    if (gnt1 !== 1'b0) begin
      n_err++; $display("FAIL hold_ack_cycle got gnt1=%b want 0", gnt1);
    end
    step();
    ack0 = 0;
    @(negedge clk);
    n_vec++;
    if ({gnt0, gnt1, vld0} !== 3'b010) begin
      n_err++; $display("FAIL hold_next_gnt got gnt=%b%b vld0=%b want 010", gnt0, gnt1, vld0);
    end
    step();
    req1 = 0;
    step();
    @(negedge clk);
    n_vec++;
    if ({vld1, res} !== {1'b1, 16'h2340}) begin
      n_err++; $display("FAIL hold_p1_res got vld1=%b res=%h want 1 2340", vld1, res);
    end
    ack1 = 1;
    step();
    ack1 = 0;
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 2; k++) begin
      step();
      req0 = 1; op0 = OP_ROL; cnt0 = 4'd1; in0 = 16'hABCD;
      step();
      req0 = 0;
      req1 = 1; op1 = OP_SLL; cnt1 = 4'd1; in1 = 16'h0003;
      if (k == 1) step();
      @(negedge clk);
      rst = 1;
      #1;
      n_vec++;
      if ({gnt0, gnt1, vld0, vld1, busy, res} !== 21'd0) begin
        n_err++;
        $display("FAIL rst_mid[%0d] got %b/%b/%b/%b/%b/%h want all 0", k, gnt0, gnt1, vld0, vld1, busy, res);
      end
      step();
      rst = 0;
      @(negedge clk);
      n_vec++;
      if ({gnt0, gnt1, vld0, vld1} !== 4'b0100) begin
        n_err++; $display("FAIL rst_regrant[%0d] got gnt=%b%b vld=%b%b want 0100", k, gnt0, gnt1, vld0, vld1);
      end
      step();
      req1 = 0;
      step();
      @(negedge clk);
      n_vec++;
      if ({vld0, vld1, res} !== {2'b01, 16'h0006}) begin
        n_err++; $display("FAIL rst_after_res[%0d] got vld=%b%b res=%h want 01 0006", k, vld0, vld1, res);
      end
      ack1 = 1;
      step();
      ack1 = 0;
    end
  endtask

  task automatic test_random();
    bit          pend[2];
    logic [1:0]  r_op[2];
    logic [3:0]  r_cnt[2];
    logic [15:0] r_in[2];
    logic        m_last;
    int          w;
    int          hold;
    logic [15:0] exp;
    do_reset();
    m_last = 1'b1;
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1;
          r_op[p] = 2'($urandom_range(0, 3));
          r_cnt[p] = 4'($urandom_range(0, 15));
          r_in[p] = 16'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = $urandom_range(0, 1);
        pend[w] = 1;
        r_op[w] = 2'($urandom_range(0, 3));
        r_cnt[w] = 4'($urandom_range(0, 15));
        r_in[w] = 16'($urandom);
      end
      req0 = pend[0]; op0 = r_op[0]; cnt0 = r_cnt[0]; in0 = r_in[0];
      req1 = pend[1]; op1 = r_op[1]; cnt1 = r_cnt[1]; in1 = r_in[1];
      w = (pend[0] && pend[1]) ? int'(!m_last) : (pend[1] ? 1 : 0);
      @(negedge clk);
      n_vec++;
      if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rnd_gnt[%0d] got gnt=%b%b want port %0d", it, gnt0, gnt1, w);
      end
      m_last = (w == 1);
      exp = ref_shift(r_op[w], int'(r_cnt[w]), r_in[w]);
      pend[w] = 0;
      step();
      if (w == 0) begin req0 = 0; in0 = 16'($urandom); end
      else begin req1 = 0; in1 = 16'($urandom); end
      @(negedge clk);
      n_vec++;
      if ({gnt0, gnt1, vld0, vld1, busy} !== 5'b00001) begin
        n_err++; $display("FAIL rnd_exec[%0d] got gnt=%b%b vld=%b%b busy=%b want 00001", it, gnt0, gnt1, vld0, vld1, busy);
      end
      step();
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        if (w == 0) ack1 = 1'($urandom_range(0, 1));
        else        ack0 = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_vec++;
        if ({vld1, vld0, res} !== {((w == 1) ? 2'b10 : 2'b01), exp}) begin
          n_err++; $display("FAIL rnd_res[%0d] got vld=%b%b res=%h want port %0d %h", it, vld0, vld1, res, w, exp);
        end
        if (h < hold) step();
      end
      ack0 = (w == 0); ack1 = (w == 1);
      step();
      ack0 = 0; ack1 = 0;
    end
    req0 = 0; req1 = 0;
  endtask

`ifdef SHIFT_ARB_STAT_EN
  task automatic run_txn(input int p);
    step();
    if (p == 0) req0 = 1; else req1 = 1;
    step();
    req0 = 0; req1 = 0;
    step();
    if (p == 0) ack0 = 1; else ack1 = 1;
    step();
    ack0 = 0; ack1 = 0;
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) run_txn(0);
    for (int i = 0; i < 2; i++) run_txn(1);
    @(negedge clk);
    n_vec++;
    if ({gcnt0, gcnt1} !== {16'd3, 16'd2}) begin
      n_err++; $display("FAIL stat_count got %0d/%0d want 3/2", gcnt0, gcnt1);
    end
    for (int i = 0; i < 2; i++) run_txn(0);
    @(negedge clk);
    n_vec++;
    if ({gcnt0, s_gcnt0, s_gcnt1} !== {16'd5, 2'd3, 2'd2}) begin
      n_err++; $display("FAIL stat_sat got %0d/%0d/%0d want 5/3/2", gcnt0, s_gcnt0, s_gcnt1);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_port0_rol();
    test_port1_ops();
    test_both_alternate();
    test_ack_hold();
    test_rst_mid();
    test_random();
`ifdef SHIFT_ARB_STAT_EN
    test_stats();
`endif
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
